// File: rtl/bsg_scatter_gather_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : bsg_scatter_gather_drain_if
// Brief    : Vector-in / element-out handshake bundle for the drain block.
// Revision : 1.0 - initial release
// ============================================================================
interface bsg_scatter_gather_drain_if #(
    parameter int els_p   = 128,
    parameter int width_p = 8
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic                       v_i;
    logic                       ready_o;
    logic [els_p-1:0]           mask_i;
    logic [els_p*width_p-1:0]   data_i;
    logic                       v_o;
    logic [width_p-1:0]         data_o;
    logic [lg_els_lp-1:0]       idx_o;
    logic [lg_els_lp-1:0]       rank_o;
    logic                       last_o;
    logic                       yumi_i;

    modport master (
        output v_i, mask_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, idx_o, rank_o, last_o
    );

    modport slave (
        input  v_i, mask_i, data_i, yumi_i,
        output ready_o, v_o, data_o, idx_o, rank_o, last_o
    );
endinterface
`default_nettype wire

// File: rtl/bsg_scatter_gather_drain.sv
`default_nettype none
// ============================================================================
// Module   : bsg_scatter_gather_drain
// Brief    : Serializes the set lanes of a masked vector, lowest lane first,
//            tagging each element with its lane index and compacted rank.
//            Option macro BSG_SCATTER_GATHER_DRAIN_PREFETCH_EN accepts the next
//            vector while the last element is taken (no inter-vector bubble).
// Revision : 1.0 - initial release
// ============================================================================
module bsg_scatter_gather_drain #(
    parameter int els_p   = 128,
    parameter int width_p = 8
) (
    input  wire logic                   clk_i,
    input  wire logic                   reset_i,
    bsg_scatter_gather_drain_if.slave   io
);
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [els_p-1:0]           mask_q, mask_d;
    logic [els_p*width_p-1:0]   data_q, data_d;
    logic [lg_els_lp-1:0]       rank_q, rank_d;

    logic [width_p-1:0]         w_lane [els_p];
    logic [lg_els_lp-1:0]       w_idx;
    logic [els_p-1:0]           w_mask_less;
    logic                       w_onehot;
    logic                       w_drain;
    logic                       w_accept;

    for (genvar k = 0; k < els_p; k++) begin : g_lane
        assign w_lane[k] = data_q[k*width_p +: width_p];
    end

    // Lowest set bit wins: scan downward so the last hit is the smallest lane.
    always_comb begin
        w_idx = '0;
        for (int k = els_p - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                w_idx = lg_els_lp'(k);
            end
        end
    end

    assign w_mask_less = mask_q - {{(els_p-1){1'b0}}, 1'b1};
    assign w_onehot    = (mask_q != '0) && ((mask_q & w_mask_less) == '0);
    assign w_drain     = (state_q == DRAIN);

    assign io.v_o    = w_drain;
    assign io.last_o = w_drain & w_onehot;
    assign io.idx_o  = w_drain ? w_idx  : '0;
    assign io.rank_o = w_drain ? rank_q : '0;
    assign io.data_o = w_drain ? w_lane[w_idx] : '0;

`ifdef BSG_SCATTER_GATHER_DRAIN_PREFETCH_EN
    assign io.ready_o = ~w_drain | (w_onehot & io.yumi_i);
`else
    assign io.ready_o = ~w_drain;
`endif

    assign w_accept = io.v_i & io.ready_o;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        rank_d  = rank_q;
        case (state_q)
            DRAIN: begin
                if (io.yumi_i) begin
                    mask_d = mask_q & w_mask_less;
                    rank_d = rank_q + lg_els_lp'(1);
                    if (w_onehot) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
            end
        endcase
        // A capture overrides the drain update; only reachable from DRAIN on the last take.
        if (w_accept) begin
            mask_d  = io.mask_i;
            data_d  = io.data_i;
            rank_d  = '0;
            state_d = (io.mask_i != '0) ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            rank_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            rank_q  <= rank_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end
endmodule
`default_nettype wire

// File: tb/tb_bsg_scatter_gather_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_scatter_gather_drain
// Brief    : Self-checking bench: queue-based element model plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_scatter_gather_drain;
    localparam int ELS = 128;
    localparam int W   = 8;
`ifdef BSG_SCATTER_GATHER_DRAIN_PREFETCH_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bsg_scatter_gather_drain_if #(.els_p(ELS), .width_p(W)) bus ();

    bsg_scatter_gather_drain #(.els_p(ELS), .width_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .io      (bus)
    );

    typedef struct {
        int idx;
        int rank;
        int data;
        bit last;
    } elem_t;

    elem_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    pops     = 0;
    int    accepts  = 0;
    bit    cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        return (exp_q.size() == 0) || (PREF && exp_q.size() == 1 && bus.yumi_i === 1'b1);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: an accepted vector becomes a list of (lane, rank, data, last) in lane order.
    always @(posedge clk_i) begin : model
        bit    rdy;
        int    n;
        int    r;
        elem_t e;
        if (reset_i) begin
            exp_q.delete();
        end else begin
            rdy = model_ready();
            if (exp_q.size() != 0 && bus.yumi_i) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (bus.v_i && rdy) begin
                accepts++;
                n = $countones(bus.mask_i);
                r = 0;
                for (int k = 0; k < ELS; k++) begin
                    if (bus.mask_i[k]) begin
                        e.idx  = k;
                        e.rank = r;
                        e.data = int'(bus.data_i[k*W +: W]);
                        e.last = (r == n - 1);
                        exp_q.push_back(e);
                        r++;
                    end
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("v_o", bus.v_o, exp_q.size() != 0);
            chk("ready_o", bus.ready_o, model_ready());
            if (exp_q.size() != 0) begin
                chk("idx_o", bus.idx_o, exp_q[0].idx);
                chk("rank_o", bus.rank_o, exp_q[0].rank);
                chk("data_o", bus.data_o, exp_q[0].data);
                chk("last_o", bus.last_o, exp_q[0].last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int p0;
        int a0;
        int lat;
        bit found;

        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b0;
        bus.mask_i = '0;
        bus.data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        cmp_en  = 1'b1;
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("rst_v", bus.v_o, 0);
        chk("rst_ready", bus.ready_o, 1);
        chk("rst_idx", bus.idx_o, 0);
        chk("rst_rank", bus.rank_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_last", bus.last_o, 0);

        // Lanes 0 and 2, consumer always taking.
        bus.mask_i    = '0;
        bus.mask_i[0] = 1'b1;
        bus.mask_i[2] = 1'b1;
        bus.data_i[0*W +: W] = 8'hAA;
        bus.data_i[2*W +: W] = 8'h55;
        bus.v_i    = 1'b1;
        bus.yumi_i = 1'b1;
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        chk("t1_idx", bus.idx_o, 0);
        chk("t1_rank", bus.rank_o, 0);
        chk("t1_data", bus.data_o, 8'hAA);
        chk("t1_last", bus.last_o, 0);
        step();
        @(negedge clk_i);
        chk("t2_idx", bus.idx_o, 2);
        chk("t2_rank", bus.rank_o, 1);
        chk("t2_data", bus.data_o, 8'h55);
        chk("t2_last", bus.last_o, 1);
        step();
        @(negedge clk_i);
        chk("t3_ready", bus.ready_o, 1);
        chk("t3_v", bus.v_o, 0);
        bus.yumi_i = 1'b0;

        // Empty vector, then a real vector the very next cycle.
        bus.mask_i = '0;
        bus.v_i    = 1'b1;
        step();
        bus.mask_i    = '0;
        bus.mask_i[4] = 1'b1;
        @(negedge clk_i);
        chk("empty_ready", bus.ready_o, 1);
        chk("empty_v", bus.v_o, 0);
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        chk("after_empty_v", bus.v_o, 1);
        chk("after_empty_idx", bus.idx_o, 4);
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;

        // All lanes set, lane k carries k, consumer takes every other cycle.
        bus.mask_i = '1;
        for (int k = 0; k < ELS; k++) bus.data_i[k*W +: W] = W'(k);
        bus.v_i = 1'b1;
        step();
        bus.v_i = 1'b0;
        p0 = pops;
        for (int c = 0; c < 400; c++) begin
            if (exp_q.size() == 0) break;
            bus.yumi_i = c[0];
            step();
        end
        bus.yumi_i = 1'b0;
        chk("ones_count", pops - p0, 128);

        // Only the top lane.
        bus.mask_i      = '0;
        bus.mask_i[127] = 1'b1;
        bus.data_i[127*W +: W] = 8'h3C;
        bus.v_i = 1'b1;
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        chk("top_idx", bus.idx_o, 127);
        chk("top_rank", bus.rank_o, 0);
        chk("top_last", bus.last_o, 1);
        chk("top_data", bus.data_o, 8'h3C);
        bus.yumi_i = 1'b1;
        step();
        bus.yumi_i = 1'b0;
        @(negedge clk_i);
        chk("top_idle_v", bus.v_o, 0);

        // Reset in the middle of a 10-element drain.
        bus.mask_i = 128'h3FF;
        bus.v_i    = 1'b1;
        step();
        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b1;
        repeat (3) step();
        bus.yumi_i = 1'b0;
        reset_i    = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_v", bus.v_o, 0);
        chk("mid_rst_ready", bus.ready_o, 1);
        bus.mask_i = 128'h30;
        bus.v_i    = 1'b1;
        step();
        bus.v_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_rank", bus.rank_o, 0);
        chk("post_rst_idx", bus.idx_o, 4);
        bus.yumi_i = 1'b1;
        repeat (2) step();
        bus.yumi_i = 1'b0;

        // Two vectors with v_i held: measure when the second stream appears.
        a0         = accepts;
        bus.mask_i = 128'h3;
        bus.v_i    = 1'b1;
        bus.yumi_i = 1'b1;
        step();
        bus.mask_i = 128'h8;
        lat   = 0;
        found = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (bus.v_o && bus.idx_o == 3) begin
                found = 1'b1;
                lat   = c;
                break;
            end
            step();
            if (accepts >= a0 + 2) bus.v_i = 1'b0;
        end
        bus.v_i = 1'b0;
        chk("b2b_found", found, 1);
        chk("b2b_latency", lat, PREF ? 3 : 4);
        step();
        bus.yumi_i = 1'b0;
        step();

        // Random traffic, including stray yumi and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            reset_i    = ($urandom_range(0, 299) == 0);
            bus.yumi_i = ($urandom_range(0, 9) < 7);
            bus.v_i    = $urandom_range(0, 1) == 1;
            if (bus.v_i) begin
                case ($urandom_range(0, 3))
                    0: bus.mask_i = '0;
                    1: begin
                        bus.mask_i = '0;
                        bus.mask_i[$urandom_range(0, ELS - 1)] = 1'b1;
                    end
                    2: for (int j = 0; j < 4; j++) bus.mask_i[j*32 +: 32] = $urandom & $urandom & $urandom;
                    default: for (int j = 0; j < 4; j++) bus.mask_i[j*32 +: 32] = $urandom;
                endcase
                for (int j = 0; j < ELS * W / 32; j++) bus.data_i[j*32 +: 32] = $urandom;
            end
            step();
        end

        reset_i    = 1'b0;
        bus.v_i    = 1'b0;
        bus.yumi_i = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        bus.yumi_i = 1'b0;
        chk("final_empty", exp_q.size(), 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
